// File: rtl/lut_offset_arbiter.sv
// rtl/lut_offset_arbiter.sv - round-robin arbiter sharing one registered log-offset LUT between PE lanes
module lut_offset_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_shift,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             lut_shift_offset,
  input  logic [23:0]            lut_log_offset,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [23:0]            rsp_data,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [TAG_W-1:0] LAST_LANE = TAG_W'(NUM_REQ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] win;
  logic             any_req;
  logic             hs;
  logic             grant;

  // Round-robin pick: scan from ptr upward; the reverse loop leaves the nearest requester in win.
  always_comb begin
    int               sum;
    logic [TAG_W-1:0] cand;
    any_req = 1'b0;
    win     = '0;
    sum     = 0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = sum[TAG_W-1:0];
      if (req_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // A new grant can be issued from IDLE or in the same cycle the pending response is taken.
  always_comb begin
    hs    = (state == RESP) && rsp_ready[tag];
    grant = any_req && ((state == IDLE) || hs);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: LOOKUP always lasts one cycle to cover the LUT's registered latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? LOOKUP : IDLE;
      LOOKUP:  state_nxt = RESP;
      RESP: begin
        if (hs) begin
          state_nxt = grant ? LOOKUP : IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant side registers: LUT index, owning lane and the advanced round-robin pointer.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr              <= '0;
      tag              <= '0;
      lut_shift_offset <= 4'd0;
    end else if (grant) begin
      lut_shift_offset <= req_shift[{win, 2'b00} +: 4];
      tag              <= win;
      ptr              <= (win == LAST_LANE) ? '0 : win + TAG_W'(1);
    end
  end

  // Outputs: strobes are gated by reset so nothing leaks while rst_n is low.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = 24'd0;
    rsp_tag   = tag;
    busy      = (state != IDLE);
    if (rst_n && grant) begin
      req_ready = NUM_REQ'(1) << win;
    end
    if (rst_n && (state == RESP)) begin
      rsp_valid = NUM_REQ'(1) << tag;
      rsp_data  = lut_log_offset;
    end
  end

endmodule
